// File: rtl/t_flip_flop.sv
// Per-lane toggle flip-flop with complementary output; Q updates on the rising clk edge (1 clock-to-Q).
// No backpressure: T is sampled on every rising edge. Async active-low reset loads RESET_VAL.
module t_flip_flop #(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qc,
  input  logic [WIDTH-1:0] T,
  input  logic             clk,
  input  logic             rst
);

  // Declared initial value gives defined state in benches that never pulse rst.
  logic [WIDTH-1:0] state = RESET_VAL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RESET_VAL;
    end else begin
      state <= state ^ T;
    end
  end

  // Qc is never stored separately, so it can never disagree with Q.
  assign Q  = state;
  assign Qc = ~state;

endmodule

// File: tb/tb_t_flip_flop.sv
// Randomized and directed bench for t_flip_flop: single lane, multi-lane, and ripple up/down chains.
module tb_t_flip_flop;

  logic       clk;
  logic       rst;
  logic       t1;
  logic [3:0] lane_t;
  logic [7:0] rnd_t;

  logic       q1, qc1;
  logic [3:0] lane_q, lane_qc;
  logic [7:0] rnd_q, rnd_qc;

  logic [3:0] up_q, up_qc, dn_q, dn_qc;
  logic [4:0] up_ck, dn_ck;

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  t_flip_flop #(.WIDTH(1)) u_t1 (
    .Q(q1), .Qc(qc1), .T(t1), .clk(clk), .rst(rst)
  );

  t_flip_flop #(.WIDTH(4)) u_lane (
    .Q(lane_q), .Qc(lane_qc), .T(lane_t), .clk(clk), .rst(rst)
  );

  t_flip_flop #(.WIDTH(8), .RESET_VAL(8'hA5)) u_rnd (
    .Q(rnd_q), .Qc(rnd_qc), .T(rnd_t), .clk(clk), .rst(rst)
  );

  // Ripple chains: up counter clocks each stage from the previous Qc, down counter from Q.
  assign up_ck[0] = clk;
  assign dn_ck[0] = clk;
  for (genvar i = 0; i < 4; i++) begin : g_chain
    assign up_ck[i+1] = up_qc[i];
    assign dn_ck[i+1] = dn_q[i];

    t_flip_flop #(.WIDTH(1)) u_up (
      .Q(up_q[i]), .Qc(up_qc[i]), .T(1'b1), .clk(up_ck[i]), .rst(rst)
    );

    t_flip_flop #(.WIDTH(1)) u_dn (
      .Q(dn_q[i]), .Qc(dn_qc[i]), .T(1'b1), .clk(dn_ck[i]), .rst(rst)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge (safe sample/drive point).
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [7:0] model;
  logic [7:0] held_t;
  logic       exp1;

  initial begin
    rst    = 1'b1;
    t1     = 1'b1;
    lane_t = 4'b0000;
    rnd_t  = 8'h00;

    // Defined state before any reset pulse.
    #1;
    check("init_q1",  {31'd0, q1}, 32'd0);
    check("init_rnd", {24'd0, rnd_q}, 32'hA5);

    // Asynchronous reset assertion, no clock edge needed.
    #1 rst = 1'b0;
    #1;
    check("rst_async_q1",  {31'd0, q1},  32'd0);
    check("rst_async_qc1", {31'd0, qc1}, 32'd1);
    check("rst_rnd_q",  {24'd0, rnd_q},  32'hA5);
    check("rst_rnd_qc", {24'd0, rnd_qc}, 32'h5A);

    // Clock edges ignored while reset is held, even with T=1.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_hold_q1",  {31'd0, q1},  32'd0);
      check("rst_hold_qc1", {31'd0, qc1}, 32'd1);
    end

    // Toggle sequence 1,0,1,0,1,0.
    rst = 1'b1;
    exp1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp1 = ~exp1;
      check("toggle_q1",  {31'd0, q1},  {31'd0, exp1});
      check("toggle_qc1", {31'd0, qc1}, {31'd0, ~exp1});
    end

    // Get to Q=1, hold for 4 edges, then one toggle back to 0.
    tick();
    check("pre_hold_q1", {31'd0, q1}, 32'd1);
    t1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold_q1", {31'd0, q1}, 32'd1);
    end
    t1 = 1'b1;
    tick();
    check("unhold_q1", {31'd0, q1}, 32'd0);

    // Reset dropped while Q is high and between clock edges.
    tick();
    check("pre_midrst_q1", {31'd0, q1}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_q1",  {31'd0, q1},  32'd0);
    check("midrst_qc1", {31'd0, qc1}, 32'd1);

    // Per-lane toggle enables.
    @(negedge clk);
    lane_t = 4'b1010;
    rst = 1'b1;
    tick();
    check("lane_e1",   {28'd0, lane_q},  32'hA);
    check("lane_e1_c", {28'd0, lane_qc}, 32'h5);
    tick();
    check("lane_e2",   {28'd0, lane_q},  32'h0);

    // Randomized T on 8 lanes, with T disturbed between edges and occasional async resets.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model = 8'hA5;
    for (int k = 0; k < 60; k++) begin
      rnd_t = 8'($urandom);
      held_t = rnd_t;
      @(posedge clk);
      #1 rnd_t = 8'($urandom);
      model = model ^ held_t;
      @(negedge clk);
      check("rnd_q",  {24'd0, rnd_q},  {24'd0, model});
      check("rnd_qc", {24'd0, rnd_qc}, {24'd0, ~model});
      if ($urandom_range(7, 0) == 0) begin
        #1 rst = 1'b0;
        #1;
        model = 8'hA5;
        check("rnd_rst", {24'd0, rnd_q}, {24'd0, model});
        rst = 1'b1;
      end
    end

    // Ripple chains counted freely until now; reset them and count 17 edges.
    rst = 1'b0;
    #1;
    check("chain_rst_up", {28'd0, up_q}, 32'd0);
    check("chain_rst_dn", {28'd0, dn_q}, 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      check("up_count",  {28'd0, up_q},  32'(k % 16));
      check("up_count_c", {28'd0, up_qc}, 32'(~(k % 16) & 15));
      check("dn_count",  {28'd0, dn_q},  32'((16 - (k % 16)) % 16));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
